// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe: pipelined INPUTS-wide AND/OR/XOR reduction with per-input bubble mask,
// optional final inversion (NAND/NOR/XNOR) and a valid/ready handshake.
// Optional feature macro: REDUCE_GATE_PIPE_STICKY_EN builds the sticky "any 1 delivered" flag.
module reduce_gate_pipe #(
   parameter int unsigned INPUTS       = 6,
   parameter logic [63:0] BUBBLES_MASK = 64'h0,
   parameter int unsigned GROUP        = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [INPUTS-1:0] in_data,
   input  logic [2:0]        in_op,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_result,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              sticky_clr,
   output logic              sticky_any
);

   // Width of the vector entering tree level `levels` (level 0 sees the raw inputs).
   function automatic int unsigned level_width(input int unsigned levels);
      int unsigned w;
      w = INPUTS;
      for (int unsigned i = 0; i < levels; i++) w = (w + GROUP - 1) / GROUP;
      return w;
   endfunction

   function automatic int unsigned calc_stages();
      int unsigned w;
      int unsigned s;
      w = INPUTS;
      s = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (w > 1) begin
            w = (w + GROUP - 1) / GROUP;
            s++;
         end
      end
      return (s < 1) ? 1 : s;
   endfunction

   localparam int unsigned STAGES = calc_stages();

   typedef enum logic [1:0] {BaseAnd, BaseOr, BaseXor} base_e;

   function automatic base_e base_of(input logic [2:0] op);
      case (op)
         3'd1, 3'd4: return BaseOr;
         3'd2, 3'd5: return BaseXor;
         default:    return BaseAnd;
      endcase
   endfunction

   // One tree level: group g of `width` live bits lands in result bit g. Missing leaves take
   // the identity value so partial groups reduce correctly.
   function automatic logic [INPUTS-1:0] reduce_level(input logic [INPUTS-1:0] v,
                                                      input int unsigned width,
                                                      input base_e base);
      logic [INPUTS-1:0] r;
      logic [INPUTS-1:0] sh;
      logic              acc;
      int unsigned       idx;
      r = '0;
      for (int unsigned g = 0; g < INPUTS; g++) begin
         acc = (base == BaseAnd);
         for (int unsigned j = 0; j < GROUP; j++) begin
            idx = g * GROUP + j;
            if (idx < width) begin
               sh = v >> idx;
               case (base)
                  BaseOr:  acc = acc | sh[0];
                  BaseXor: acc = acc ^ sh[0];
                  default: acc = acc & sh[0];
               endcase
            end
         end
         // Shift in from the top so group 0 ends up at bit 0 after all iterations.
         r = {acc, r[INPUTS-1:1]};
      end
      return r;
   endfunction

   logic [INPUTS-1:0] bubbled;
   logic [INPUTS-1:0] lvl_q [STAGES];
   logic [INPUTS-1:0] lvl_d [STAGES];
   logic [2:0]        op_q  [STAGES];
   logic [2:0]        op_d  [STAGES];
   logic              vld_q [STAGES];
   logic              vld_d [STAGES];
   logic              advance;

   assign bubbled  = in_data ^ BUBBLES_MASK[INPUTS-1:0];
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [INPUTS-1:0] src;
      logic [2:0]        src_op;
      logic [INPUTS-1:0] red;

      if (k == 0) begin : g_first
         assign src      = bubbled;
         assign src_op   = in_op;
         assign vld_d[k] = in_valid;
      end else begin : g_next
         assign src      = lvl_q[k-1];
         assign src_op   = op_q[k-1];
         assign vld_d[k] = vld_q[k-1];
      end

      assign red      = reduce_level(src, level_width(k), base_of(src_op));
      assign op_d[k]  = src_op;

      if (k == STAGES - 1) begin : g_last
         logic reserved;
         logic invert;
         logic unused_red;
         assign reserved   = (src_op[2:1] == 2'b11);
         assign invert     = (src_op == 3'd3) || (src_op == 3'd4) || (src_op == 3'd5);
         assign lvl_d[k]   = {{(INPUTS-1){1'b0}}, (red[0] ^ invert) & ~reserved};
         assign unused_red = ^red[INPUTS-1:1];
      end else begin : g_mid
         assign lvl_d[k] = red;
      end
   end

   // Whole pipe shifts together on advance and freezes otherwise; reset drops every token.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            lvl_q[k] <= '0;
            op_q[k]  <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= vld_d[k];
            lvl_q[k] <= lvl_d[k];
            op_q[k]  <= op_d[k];
         end
      end
   end

   assign out_valid  = vld_q[STAGES-1];
   assign out_result = lvl_q[STAGES-1][0];
   assign out_err    = op_q[STAGES-1][2] & op_q[STAGES-1][1];

   logic unused_tail;
   assign unused_tail = ^{lvl_q[STAGES-1][INPUTS-1:1], op_q[STAGES-1][0]};

`ifdef REDUCE_GATE_PIPE_STICKY_EN
   logic sticky_q;

   // Remember any clean 1 handed downstream; a set beats a same-cycle clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= 1'b0;
      end else if (out_valid && out_ready && out_result && !out_err) begin
         sticky_q <= 1'b1;
      end else if (sticky_clr) begin
         sticky_q <= 1'b0;
      end
   end

   assign sticky_any = sticky_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky_any        = 1'b0;
`endif

endmodule
